// File: rtl/id_ex_operand_stage.sv
// ---------------------------------------------------------------------------
// id_ex_operand_stage
//   ID/EX pipeline register plus EX-stage operand forwarding, feeding the ALU.
//   Decoded ID fields are captured at the end of ID. RAW hazards against the
//   EX/MEM and MEM/WB producers are resolved combinationally on the registered
//   source addresses. The resolved values drive the ALU a/b inputs and the
//   store-data path.
//
// Ports
//   clk, reset                  clock, synchronous active-low reset
//   stall_i / flush_i           hold EX contents / load a bubble (flush wins)
//   valid_i ... reg_write_i     decoded ID-stage fields
//   exmem_* / memwb_*           bypass sources (write enable, rd, data)
//   alu_operation_o, a_o, b_o,
//   shamt_o                     ALU inputs for the current EX instruction
//   rt_fwd_o                    forwarded rt, used as store data in MEM
//   rd_addr_o, reg_write_o,
//   valid_o                     destination and write-back control to EX/MEM
// ---------------------------------------------------------------------------

// Forwarding mux for one source operand. The EX/MEM producer is younger than
// the MEM/WB producer, so it wins. r0 is hardwired to zero and never bypassed.
module id_ex_fwd_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic [ADDR_WIDTH-1:0] i_src,
  input  logic [DATA_WIDTH-1:0] i_reg_data,
  input  logic                  i_exmem_we,
  input  logic [ADDR_WIDTH-1:0] i_exmem_rd,
  input  logic [DATA_WIDTH-1:0] i_exmem_data,
  input  logic                  i_memwb_we,
  input  logic [ADDR_WIDTH-1:0] i_memwb_rd,
  input  logic [DATA_WIDTH-1:0] i_memwb_data,
  output logic [DATA_WIDTH-1:0] o_fwd
);
  logic w_hit_ex;
  logic w_hit_wb;

  assign w_hit_ex = i_exmem_we && (i_exmem_rd != '0) && (i_exmem_rd == i_src);
  assign w_hit_wb = i_memwb_we && (i_memwb_rd != '0) && (i_memwb_rd == i_src);

  always_comb begin
    o_fwd = i_reg_data;
    if (w_hit_ex)      o_fwd = i_exmem_data;
    else if (w_hit_wb) o_fwd = i_memwb_data;
  end
endmodule

module id_ex_operand_stage #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  stall_i,
  input  logic                  flush_i,
  input  logic                  valid_i,
  input  logic [3:0]            alu_operation_i,
  input  logic [DATA_WIDTH-1:0] rs_data_i,
  input  logic [DATA_WIDTH-1:0] rt_data_i,
  input  logic [15:0]           imm_i,
  input  logic [4:0]            shamt_i,
  input  logic [ADDR_WIDTH-1:0] rs_addr_i,
  input  logic [ADDR_WIDTH-1:0] rt_addr_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  input  logic                  alu_src_i,
  input  logic                  sign_ext_i,
  input  logic                  reg_write_i,
  input  logic                  exmem_reg_write_i,
  input  logic [ADDR_WIDTH-1:0] exmem_rd_i,
  input  logic [DATA_WIDTH-1:0] exmem_data_i,
  input  logic                  memwb_reg_write_i,
  input  logic [ADDR_WIDTH-1:0] memwb_rd_i,
  input  logic [DATA_WIDTH-1:0] memwb_data_i,
  output logic [3:0]            alu_operation_o,
  output logic [DATA_WIDTH-1:0] a_o,
  output logic [DATA_WIDTH-1:0] b_o,
  output logic [4:0]            shamt_o,
  output logic [DATA_WIDTH-1:0] rt_fwd_o,
  output logic [ADDR_WIDTH-1:0] rd_addr_o,
  output logic                  reg_write_o,
  output logic                  valid_o
);
  localparam int NUM_SRC = 2;   // index 0 = rs, index 1 = rt

  // EX-stage registers
  logic                  r_valid;
  logic                  r_reg_write;
  logic [3:0]            r_alu_op;
  logic [DATA_WIDTH-1:0] r_rs_data;
  logic [DATA_WIDTH-1:0] r_rt_data;
  logic [15:0]           r_imm;
  logic [4:0]            r_shamt;
  logic [ADDR_WIDTH-1:0] r_rs_addr;
  logic [ADDR_WIDTH-1:0] r_rt_addr;
  logic [ADDR_WIDTH-1:0] r_rd_addr;
  logic                  r_alu_src;
  logic                  r_sign_ext;

  logic [NUM_SRC-1:0][ADDR_WIDTH-1:0] w_src;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0] w_reg_data;
  logic [NUM_SRC-1:0][DATA_WIDTH-1:0] w_fwd;
  logic [DATA_WIDTH-1:0]              w_ext_imm;

  assign w_src      = {r_rt_addr, r_rs_addr};
  assign w_reg_data = {r_rt_data, r_rs_data};

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
    id_ex_fwd_unit #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
    ) u_fwd (
      .i_src        (w_src[g]),
      .i_reg_data   (w_reg_data[g]),
      .i_exmem_we   (exmem_reg_write_i),
      .i_exmem_rd   (exmem_rd_i),
      .i_exmem_data (exmem_data_i),
      .i_memwb_we   (memwb_reg_write_i),
      .i_memwb_rd   (memwb_rd_i),
      .i_memwb_data (memwb_data_i),
      .o_fwd        (w_fwd[g])
    );
  end

  assign w_ext_imm = r_sign_ext ? {{(DATA_WIDTH-16){r_imm[15]}}, r_imm}
                                : {{(DATA_WIDTH-16){1'b0}}, r_imm};

  // Reset and flush both leave an all-zero bubble; flush beats stall so a
  // redirect is never swallowed by a concurrent hazard hold.
  always_ff @(posedge clk) begin
    if (!reset || flush_i) begin
      r_valid     <= 1'b0;
      r_reg_write <= 1'b0;
      r_alu_op    <= '0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm       <= '0;
      r_shamt     <= '0;
      r_rs_addr   <= '0;
      r_rt_addr   <= '0;
      r_rd_addr   <= '0;
      r_alu_src   <= 1'b0;
      r_sign_ext  <= 1'b0;
    end else if (stall_i) begin
      // Control fields hold; operand data absorbs any bypass value now, so a
      // producer retiring out of MEM/WB during the stall is not lost.
      r_rs_data <= w_fwd[0];
      r_rt_data <= w_fwd[1];
    end else begin
      r_valid     <= valid_i;
      r_reg_write <= reg_write_i;
      r_alu_op    <= alu_operation_i;
      r_rs_data   <= rs_data_i;
      r_rt_data   <= rt_data_i;
      r_imm       <= imm_i;
      r_shamt     <= shamt_i;
      r_rs_addr   <= rs_addr_i;
      r_rt_addr   <= rt_addr_i;
      r_rd_addr   <= rd_addr_i;
      r_alu_src   <= alu_src_i;
      r_sign_ext  <= sign_ext_i;
    end
  end

  assign a_o             = w_fwd[0];
  assign rt_fwd_o        = w_fwd[1];
  assign b_o             = r_alu_src ? w_ext_imm : w_fwd[1];
  assign alu_operation_o = r_alu_op;
  assign shamt_o         = r_shamt;
  assign rd_addr_o       = r_rd_addr;
  assign reg_write_o     = r_reg_write & r_valid;
  assign valid_o         = r_valid;
endmodule

// File: tb/tb_id_ex_operand_stage.sv
module tb_id_ex_operand_stage;
  logic        clk = 1'b0;
  logic        reset, stall_i, flush_i, valid_i;
  logic [3:0]  alu_operation_i;
  logic [31:0] rs_data_i, rt_data_i;
  logic [15:0] imm_i;
  logic [4:0]  shamt_i, rs_addr_i, rt_addr_i, rd_addr_i;
  logic        alu_src_i, sign_ext_i, reg_write_i;
  logic        exmem_reg_write_i, memwb_reg_write_i;
  logic [4:0]  exmem_rd_i, memwb_rd_i;
  logic [31:0] exmem_data_i, memwb_data_i;
  logic [3:0]  alu_operation_o;
  logic [31:0] a_o, b_o, rt_fwd_o;
  logic [4:0]  shamt_o, rd_addr_o;
  logic        reg_write_o, valid_o;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_operand_stage #(.DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk(clk), .reset(reset), .stall_i(stall_i), .flush_i(flush_i),
    .valid_i(valid_i), .alu_operation_i(alu_operation_i),
    .rs_data_i(rs_data_i), .rt_data_i(rt_data_i), .imm_i(imm_i),
    .shamt_i(shamt_i), .rs_addr_i(rs_addr_i), .rt_addr_i(rt_addr_i),
    .rd_addr_i(rd_addr_i), .alu_src_i(alu_src_i), .sign_ext_i(sign_ext_i),
    .reg_write_i(reg_write_i), .exmem_reg_write_i(exmem_reg_write_i),
    .exmem_rd_i(exmem_rd_i), .exmem_data_i(exmem_data_i),
    .memwb_reg_write_i(memwb_reg_write_i), .memwb_rd_i(memwb_rd_i),
    .memwb_data_i(memwb_data_i), .alu_operation_o(alu_operation_o),
    .a_o(a_o), .b_o(b_o), .shamt_o(shamt_o), .rt_fwd_o(rt_fwd_o),
    .rd_addr_o(rd_addr_o), .reg_write_o(reg_write_o), .valid_o(valid_o)
  );

  // Reference model: the instruction currently sitting in EX
  typedef struct {
    bit          valid, rw, alu_src, sign;
    int unsigned op, shamt, rs, rt, rd, imm;
    int unsigned rs_data, rt_data;
  } ex_t;
  ex_t m;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  // Newest writer of a nonzero register supplies the value
  function automatic int unsigned fwd(input int unsigned src, input int unsigned dflt);
    if (src == 0) return dflt;
    if (exmem_reg_write_i && exmem_rd_i == src) return exmem_data_i;
    if (memwb_reg_write_i && memwb_rd_i == src) return memwb_data_i;
    return dflt;
  endfunction

  function automatic int unsigned ext(input int unsigned imm, input bit sign);
    if (sign && imm >= 32768) return imm + 32'hFFFF_0000;
    return imm;
  endfunction

  // Advance one clock, updating the model with the same edge's inputs
  task automatic tick();
    ex_t n;
    n = m;
    if (!reset || flush_i) n = '{default: 0};
    else if (stall_i) begin
      n.rs_data = fwd(m.rs, m.rs_data);
      n.rt_data = fwd(m.rt, m.rt_data);
    end else begin
      n.valid = valid_i;  n.rw = reg_write_i;  n.op = alu_operation_i;
      n.rs_data = rs_data_i;  n.rt_data = rt_data_i;  n.imm = imm_i;
      n.shamt = shamt_i;  n.rs = rs_addr_i;  n.rt = rt_addr_i;  n.rd = rd_addr_i;
      n.alu_src = alu_src_i;  n.sign = sign_ext_i;
    end
    @(posedge clk);
    m = n;
    @(negedge clk);
  endtask

  task automatic check_all();
    int unsigned rtf;
    rtf = fwd(m.rt, m.rt_data);
    chk("valid", {31'b0, valid_o}, m.valid);
    chk("reg_write", {31'b0, reg_write_o}, (m.rw && m.valid) ? 1 : 0);
    chk("alu_op", {28'b0, alu_operation_o}, m.op);
    chk("shamt", {27'b0, shamt_o}, m.shamt);
    chk("rd", {27'b0, rd_addr_o}, m.rd);
    chk("a", a_o, fwd(m.rs, m.rs_data));
    chk("rt_fwd", rt_fwd_o, rtf);
    chk("b", b_o, m.alu_src ? ext(m.imm, m.sign) : rtf);
  endtask

  initial begin
    m = '{default: 0};
    reset = 0; stall_i = 0; flush_i = 0; valid_i = 0; alu_operation_i = 0;
    rs_data_i = 0; rt_data_i = 0; imm_i = 0; shamt_i = 0;
    rs_addr_i = 0; rt_addr_i = 0; rd_addr_i = 0;
    alu_src_i = 0; sign_ext_i = 0; reg_write_i = 0;
    exmem_reg_write_i = 0; exmem_rd_i = 0; exmem_data_i = 0;
    memwb_reg_write_i = 0; memwb_rd_i = 0; memwb_data_i = 0;

    // 1. reset
    valid_i = 1; reg_write_i = 1; alu_operation_i = 4'hA; rs_data_i = 32'hDEAD;
    tick(); tick();
    reset = 1; #1;
    chk("rst_valid", {31'b0, valid_o}, 0);
    chk("rst_rw", {31'b0, reg_write_o}, 0);
    chk("rst_op", {28'b0, alu_operation_o}, 0);
    chk("rst_a", a_o, 0);
    chk("rst_b", b_o, 0);

    // 2. plain load, 1-cycle latency
    rs_data_i = 5; rt_data_i = 7; alu_operation_i = 4'b0011;
    rs_addr_i = 1; rt_addr_i = 2; rd_addr_i = 9;
    tick(); #1;
    chk("ld_a", a_o, 5);
    chk("ld_b", b_o, 7);
    chk("ld_valid", {31'b0, valid_o}, 1);
    chk("ld_op", {28'b0, alu_operation_o}, 3);
    chk("ld_rw", {31'b0, reg_write_o}, 1);

    // 3. EX/MEM beats MEM/WB
    rs_addr_i = 8; tick();
    exmem_reg_write_i = 1; exmem_rd_i = 8; exmem_data_i = 32'h11;
    memwb_reg_write_i = 1; memwb_rd_i = 8; memwb_data_i = 32'h22;
    #1 chk("fwd_ex", a_o, 32'h11);
    exmem_reg_write_i = 0;
    #1 chk("fwd_wb", a_o, 32'h22);
    memwb_reg_write_i = 0;

    // 4. r0 never forwarded; immediate extension
    rt_addr_i = 0; rt_data_i = 0; tick();
    exmem_reg_write_i = 1; exmem_rd_i = 0; exmem_data_i = 32'hFF;
    #1 chk("r0_b", b_o, 0);
    alu_src_i = 1; imm_i = 16'h8000; sign_ext_i = 1; tick(); #1;
    chk("sext_b", b_o, 32'hFFFF_8000);
    sign_ext_i = 0; tick(); #1;
    chk("zext_b", b_o, 32'h0000_8000);
    exmem_reg_write_i = 0; alu_src_i = 0;

    // 5. stall captures a retiring MEM/WB value
    rs_addr_i = 3; rs_data_i = 0; tick();
    stall_i = 1; memwb_reg_write_i = 1; memwb_rd_i = 3; memwb_data_i = 32'h33;
    #1 chk("stl_fwd", a_o, 32'h33);
    tick();
    memwb_reg_write_i = 0;
    #1 chk("stl_hold", a_o, 32'h33);
    chk("stl_valid", {31'b0, valid_o}, 1);

    // 6. flush beats stall
    flush_i = 1; tick(); #1;
    chk("fl_valid", {31'b0, valid_o}, 0);
    chk("fl_rw", {31'b0, reg_write_o}, 0);
    chk("fl_op", {28'b0, alu_operation_o}, 0);
    flush_i = 0; stall_i = 0;

    // Randomized traffic against the model; small address space for frequent hits
    for (int i = 0; i < 400; i++) begin
      reset = ($urandom_range(0, 99) >= 3);
      flush_i = ($urandom_range(0, 9) == 0);
      stall_i = ($urandom_range(0, 4) == 0);
      valid_i = $urandom; reg_write_i = $urandom;
      alu_operation_i = $urandom; rs_data_i = $urandom; rt_data_i = $urandom;
      imm_i = $urandom; shamt_i = $urandom;
      rs_addr_i = $urandom_range(0, 3); rt_addr_i = $urandom_range(0, 3);
      rd_addr_i = $urandom;
      alu_src_i = $urandom; sign_ext_i = $urandom;
      exmem_reg_write_i = $urandom; exmem_rd_i = $urandom_range(0, 3);
      exmem_data_i = $urandom;
      memwb_reg_write_i = $urandom; memwb_rd_i = $urandom_range(0, 3);
      memwb_data_i = $urandom;
      #1 check_all();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
